// File: rtl/double_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : double_buffer_pkg
//  Description : Shared types and helpers for the ping-pong bank controller.
//                Write/read state encodings, dropped-count width and the
//                bank-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package double_buffer_pkg;

  typedef enum logic [0:0] {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } write_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } read_state_t;

  // The bank is selected by the single MSB of the SRAM address.
  localparam int BANK_SELECT_WIDTH = 1;
  localparam int DROP_COUNT_WIDTH  = 16;

  // The bank the writer is not using is the one the reader may own.
  function automatic logic other_bank(input logic bank);
    return ~bank;
  endfunction

endpackage
`default_nettype wire

// File: rtl/double_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : double_buffer_ctrl_if
//  Description : Producer, consumer and SRAM-port bundle of the ping-pong
//                controller. master = controller, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface double_buffer_ctrl_if
  import double_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = 10,
  parameter int BANK_ADDRESS_WIDTH = 7
);
  logic                              writeValid;
  logic [DATA_WIDTH-1:0]             writeData;
  logic                              writeReady;
  logic                              readValid;
  logic [DATA_WIDTH-1:0]             readData;
  logic                              readLast;
  logic                              readReady;
  logic                              sramWriteEnable;
  logic [BANK_ADDRESS_WIDTH:0]       sramWriteAddress;
  logic [DATA_WIDTH-1:0]             sramWriteData;
  logic [BANK_ADDRESS_WIDTH:0]       sramReadAddress;
  logic [DATA_WIDTH-1:0]             sramReadData;
  logic [DROP_COUNT_WIDTH-1:0]       droppedCount;

  modport master (
    input  writeValid, writeData, readReady, sramReadData,
    output writeReady, readValid, readData, readLast,
           sramWriteEnable, sramWriteAddress, sramWriteData,
           sramReadAddress, droppedCount
  );

  modport slave (
    output writeValid, writeData, readReady, sramReadData,
    input  writeReady, readValid, readData, readLast,
           sramWriteEnable, sramWriteAddress, sramWriteData,
           sramReadAddress, droppedCount
  );
endinterface
`default_nettype wire

// File: rtl/double_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : double_buffer_ctrl
//  Description : Ping-pong controller splitting one dual-port SRAM into two
//                banks. Fills one bank from the pixel stream while streaming
//                the other full bank to the consumer; swaps only when the
//                write bank is complete and the other bank is drained.
//                Optional macro DOUBLE_BUFFER_DROP_EN: never backpressure the
//                producer, discard and count words arriving while waiting.
//                BANK_WORDS legal range: 2 .. 2**BANK_ADDRESS_WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module double_buffer_ctrl
  import double_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = 10,
  parameter int BANK_ADDRESS_WIDTH = 7,
  parameter int BANK_WORDS         = 128
) (
  input  wire logic             clock,
  input  wire logic             reset,
  double_buffer_ctrl_if.master  bus
);

  localparam logic [BANK_ADDRESS_WIDTH-1:0] LAST_INDEX =
    BANK_ADDRESS_WIDTH'(BANK_WORDS - 1);

  write_state_t                  write_state, write_state_next;
  read_state_t                   read_state,  read_state_next;
  logic                          write_bank;
  logic                          read_bank;
  logic [1:0]                    full;
  logic [BANK_ADDRESS_WIDTH-1:0] write_count;
  logic [BANK_ADDRESS_WIDTH-1:0] read_count;
  logic [DROP_COUNT_WIDTH-1:0]   dropped_count;
  logic [DATA_WIDTH-1:0]         pixel_in;
  logic [DATA_WIDTH-1:0]         pixel_out;

  logic write_fire, write_last, other_free;
  logic read_fire, read_last, read_start;

  assign pixel_in  = bus.writeData;
  assign pixel_out = bus.sramReadData;

  // Handshake qualifiers; other_free uses registered flags only, so a bank
  // released this cycle is still seen busy by the writer.
  always_comb begin
    other_free = !full[other_bank(write_bank)] &&
                 !((read_state == R_READ) && (read_bank == other_bank(write_bank)));
    write_fire = bus.writeValid && bus.writeReady && (write_state == W_FILL);
    write_last = write_fire && (write_count == LAST_INDEX);
    read_fire  = (read_state == R_READ) && bus.readReady;
    read_last  = read_fire && (read_count == LAST_INDEX);
    read_start = (read_state == R_IDLE) && full[other_bank(write_bank)];
  end

  // Write FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) write_state <= W_FILL;
    else       write_state <= write_state_next;
  end

  // Write FSM next state: wait only when a bank completes with no free partner.
  always_comb begin
    write_state_next = write_state;
    case (write_state)
      W_FILL:  if (write_last && !other_free) write_state_next = W_WAIT;
      W_WAIT:  if (other_free)                write_state_next = W_FILL;
      default: write_state_next = W_FILL;
    endcase
  end

  // Write FSM outputs and SRAM write port.
  always_comb begin
`ifdef DOUBLE_BUFFER_DROP_EN
    bus.writeReady     = 1'b1;
`else
    bus.writeReady     = (write_state == W_FILL);
`endif
    bus.sramWriteEnable  = write_fire;
    bus.sramWriteAddress = {write_bank, write_count};
    bus.sramWriteData    = pixel_in;
  end

  // Write-side counter and bank pointer; bank flips on completion or on leaving W_WAIT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_count <= '0;
      write_bank  <= 1'b0;
    end else begin
      if (write_fire)
        write_count <= write_last ? '0 : write_count + 1'b1;
      if (other_free && (write_last || (write_state == W_WAIT)))
        write_bank <= other_bank(write_bank);
    end
  end

  // Bank-full flags: reader clears the bank it drained, writer sets the one it filled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full <= 2'b00;
    end else begin
      if (read_last)  full[read_bank]  <= 1'b0;
      if (write_last) full[write_bank] <= 1'b1;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) read_state <= R_IDLE;
    else       read_state <= read_state_next;
  end

  // Read FSM next state.
  always_comb begin
    read_state_next = read_state;
    case (read_state)
      R_IDLE:  if (read_start) read_state_next = R_READ;
      R_READ:  if (read_last)  read_state_next = R_IDLE;
      default: read_state_next = R_IDLE;
    endcase
  end

  // Read-side bank latch and word counter; the counter is the registered address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_bank  <= 1'b0;
      read_count <= '0;
    end else if (read_start) begin
      read_bank  <= other_bank(write_bank);
      read_count <= '0;
    end else if (read_fire) begin
      read_count <= read_last ? '0 : read_count + 1'b1;
    end
  end

  // Read FSM outputs; SRAM samples on negedge so data is valid this cycle.
  always_comb begin
    bus.readValid       = (read_state == R_READ);
    bus.readLast        = (read_state == R_READ) && (read_count == LAST_INDEX);
    bus.readData        = pixel_out;
    bus.sramReadAddress = {read_bank, read_count};
    bus.droppedCount    = dropped_count;
  end

`ifdef DOUBLE_BUFFER_DROP_EN
  // Count words discarded while the writer waits for a free bank; saturates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dropped_count <= '0;
    else if ((write_state == W_WAIT) && bus.writeValid && (dropped_count != '1))
      dropped_count <= dropped_count + 1'b1;
  end
`else
  assign dropped_count = '0;
`endif

endmodule
`default_nettype wire

// File: doc/double_buffer_ctrl.md
Name: double_buffer_ctrl

Overview:
- Ping-pong controller for the dual-port frame/line store (sramDp, write port posedge, read port negedge).
- Splits the SRAM into two banks. Accepts a pixel stream into the write bank and streams the other full bank out to a consumer.
- Swaps banks only when the write bank is complete and the other bank has been fully drained.
- Sits between the camera pixel pipeline and the blob/centroid stage; the parent doubleBuffer top wires it to one sramDp.

Parameters:
- DATA_WIDTH, 10: pixel word width.
- BANK_ADDRESS_WIDTH, 7: per-bank address width. SRAM ADDRESS_WIDTH = BANK_ADDRESS_WIDTH+1; MSB selects the bank.
- BANK_WORDS, 128: words per bank buffer. Legal range 2 to 2^BANK_ADDRESS_WIDTH.

Ports:
- clock  in  1  single system clock, all logic posedge.
- reset  in  1  asynchronous, active-high.
- writeValid  in  1  producer word valid.
- writeData  in  DATA_WIDTH  producer word.
- writeReady  out  1  controller accepts word.
- readValid  out  1  consumer word valid.
- readData  out  DATA_WIDTH  consumer word (= sramReadData).
- readLast  out  1  marks last word of bank.
- readReady  in  1  consumer accepts word.
- sramWriteEnable  out  1  to sramDp writeEnableA.
- sramWriteAddress  out  BANK_ADDRESS_WIDTH+1  to addressA.
- sramWriteData  out  DATA_WIDTH  to dataInA.
- sramReadAddress  out  BANK_ADDRESS_WIDTH+1  to addressB.
- sramReadData  in  DATA_WIDTH  from dataOutB.
- droppedCount  out  16  dropped-word count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - writeBank=0, both bank-full flags=0, write state W_FILL, read state R_IDLE, counters=0.
  - Outputs: writeReady=1, readValid=0, readLast=0, sramWriteEnable=0, addresses=0, droppedCount=0.
- Write handshake: a word transfers when writeValid&&writeReady.
  - sramWriteEnable = writeValid&&writeReady, combinational.
  - sramWriteAddress = {writeBank, writeCount}; sramWriteData = writeData.
  - Data lands in memory at the same edge.
- Write FSM:
  - W_FILL: writeReady=1. On a transfer with writeCount==BANK_WORDS-1:
    - Set full[writeBank] at that edge and clear writeCount.
    - If the other bank is free (not full and not being read) at that cycle, flip writeBank at that edge and stay in W_FILL; no stall.
    - Otherwise go to W_WAIT.
  - W_WAIT: writeReady=0. When the other bank becomes free (registered flags), flip writeBank and return to W_FILL on the next edge.
- Read FSM:
  - R_IDLE: readValid=0. If full[~writeBank] is set, load readBank=~writeBank, readCount=0, and go to R_READ.
  - R_READ: readValid=1; sramReadAddress = {readBank, readCount}, registered.
    - The SRAM samples on negedge, so readData is valid in the same cycle; the consumer samples at the next posedge.
    - readLast = (readCount==BANK_WORDS-1).
    - On readValid&&readReady: increment readCount. On the last word, clear full[readBank] and return to R_IDLE.
    - Stall (readReady=0) holds the address and data stable.
- Latency: last write handshake in cycle N → first readValid in cycle N+2. One bubble cycle between consecutive banks on the read side.
- Simultaneous events:
  - Reader releases a bank in the same cycle the writer completes its bank: the writer sees the bank as busy, enters W_WAIT for exactly 1 cycle, then swaps.
- Wrap-around: counters compare to BANK_WORDS-1; they never rely on natural overflow.
- Reset mid-operation: all partial bank contents are discarded. A partly read bank is not resumed.

Optional Feature:
- Macro DOUBLE_BUFFER_DROP_EN.
- Defined:
  - writeReady is tied to 1.
  - In W_WAIT, incoming valid words are discarded: no SRAM write, and droppedCount increments, saturating at 16'hFFFF.
  - The writer keeps waiting; the first accepted word after the swap starts the new bank at offset 0.
- Undefined: backpressure as above, and droppedCount is constant 0.

Decomposition:
- Package double_buffer_pkg:
  - enums for the write states (W_FILL, W_WAIT) and read states (R_IDLE, R_READ);
  - the bank-select localparam helper.
- No sub-module: counters and both FSMs are inline.
- sramDp stays external, instantiated by the parent top.

Test Plan (BANK_WORDS=4, BANK_ADDRESS_WIDTH=2, readReady=1 unless stated):
- Write words 1..4 continuously → sramWriteAddress 0,1,2,3 with sramWriteEnable=1; writeBank flips to 1; readValid first high 2 cycles after the 4th write with address 0, then readData 1,2,3,4 and readLast on 4.
- Write 8 words with readReady=0 → words 5..8 go to addresses 4..7; after the 8th, writeReady=0 (W_WAIT). Raise readReady → bank 0 drains; 1 cycle later writeReady=1 and writeBank=0.
- readReady toggling 1,0,0,1 mid-bank → readData and sramReadAddress held during stall; no word skipped or duplicated.
- Reader releases bank 1 in the same cycle the writer finishes bank 0 → writeReady=0 for exactly 1 cycle, then writing resumes at address 4.
- Assert reset after 2 writes and during a read → all outputs at reset values immediately. The next write goes to address 0 and readValid stays 0 until 4 new words are written.
- DOUBLE_BUFFER_DROP_EN with both banks full and 3 extra valid words → droppedCount=3, no sramWriteEnable; after the drain the next word is written to the freed bank at offset 0.
